// File: rtl/ads_i2c_target.sv
// ads_i2c_target: I2C target that emulates an ADS1115-style 16-bit ADC.
//
// The pointer, config and conversion registers are visible on a single I2C
// bus at a fixed 7-bit address. Setting OS (config bit 15) starts a timed
// conversion. When the conversion ends, the sample on conv_data_i is latched.
//
// Ports:
//   clk_i        system clock (>= 16x SCL)
//   rst_ni       asynchronous active-low reset
//   scl_i/sda_i  raw bus inputs, asynchronous to clk_i
//   sda_oe_o     1 = pull SDA low (open-drain, tristated externally)
//   conv_data_i  two's-complement sample captured at conversion end
//   config_o     current config register
//   config_wr_o  one-cycle pulse when a 16-bit config write commits
//   busy_o       conversion in progress
//
// Build option: define ADS_TARGET_GLITCH_FILTER_EN to insert a 3-sample
// majority filter after the synchronizers. The filter adds 2 cycles of input
// latency and drops pulses of 1 clk_i.
module ads_i2c_target #(
  parameter logic [6:0]  ADDRESS     = 7'b1001001,
  parameter int unsigned CONV_CYCLES = 4000,
  parameter logic [15:0] CONFIG_RST  = 16'h8583
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe_o,
  input  logic [15:0] conv_data_i,
  output logic [15:0] config_o,
  output logic        config_wr_o,
  output logic        busy_o
);
  localparam int CW = $clog2(CONV_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RMACK, IGNORE
  } state_e;

  // ---------------- input path ----------------
  logic [1:0] scl_sync, sda_sync;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

  logic scl_s, sda_s;
`ifdef ADS_TARGET_GLITCH_FILTER_EN
  logic [2:0] scl_hist, sda_hist;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_hist <= 3'b111;
      sda_hist <= 3'b111;
    end else begin
      scl_hist <= {scl_hist[1:0], scl_sync[1]};
      sda_hist <= {sda_hist[1:0], sda_sync[1]};
    end
  end
  // Majority of 3: the output follows once two samples agree. A 1-cycle
  // pulse only ever occupies one slot, so it never shows up here.
  assign scl_s = (scl_hist[0] & scl_hist[1]) | (scl_hist[0] & scl_hist[2]) |
                 (scl_hist[1] & scl_hist[2]);
  assign sda_s = (sda_hist[0] & sda_hist[1]) | (sda_hist[0] & sda_hist[2]) |
                 (sda_hist[1] & sda_hist[2]);
`else
  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];
`endif

  logic scl_q, sda_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_s;
      sda_q <= sda_s;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

  // ---------------- registers ----------------
  state_e        state_q, state_d;
  logic [3:0]    bit_cnt_q;
  logic [7:0]    shreg_q, msb_q, tx_sr_q;
  logic [1:0]    ptr_q, wbyte_q, rd_idx_q;
  logic          mack_q, oe_q, oe_d;
  logic [15:0]   shadow_q, cfg_q, conv_q;
  logic          busy_q, cfg_wr_q;
  logic [CW-1:0] cnt_q;

  // Register the pointer selects, as it would be seen by a read.
  logic [15:0] reg_rd;
  always_comb begin
    unique case (ptr_q)
      2'd0:    reg_rd = conv_q;
      2'd1:    reg_rd = {~busy_q, cfg_q[14:0]};
      2'd2:    reg_rd = 16'h8000;
      default: reg_rd = 16'h7FFF;
    endcase
  end

  // Byte that the next SCL fall starts to shift out. A new byte is loaded when
  // RDATA is entered. Inside RDATA the current byte keeps shifting.
  logic [1:0] nxt_idx;
  logic [7:0] nxt_byte, tx_cur;
  always_comb begin
    nxt_idx = 2'd0;
    if (state_q == RMACK) nxt_idx = (rd_idx_q == 2'd2) ? 2'd2 : rd_idx_q + 2'd1;
    nxt_byte = 8'hFF;
    unique case (nxt_idx)
      2'd0:    nxt_byte = shadow_q[15:8];
      2'd1:    nxt_byte = shadow_q[7:0];
      default: nxt_byte = 8'hFF;
    endcase
    tx_cur = (state_q == RDATA) ? {tx_sr_q[6:0], 1'b1} : nxt_byte;
  end

  // The config write commits on the 8th rise of the LSB byte. The LSB itself
  // is only complete once the live SDA sample is appended.
  logic        commit;
  logic [15:0] commit_data;
  assign commit      = scl_rise && !start_det && !stop_det && state_q == WDATA &&
                       bit_cnt_q == 4'd7 && wbyte_q == 2'd1 && ptr_q == 2'd1;
  assign commit_data = {msb_q, shreg_q[6:0], sda_s};

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (stop_det)       state_d = IDLE;
    else if (start_det) state_d = ADDR;
    else if (scl_fall) begin
      unique case (state_q)
        ADDR:      if (bit_cnt_q == 4'd8)
                     state_d = (shreg_q[7:1] == ADDRESS) ? ADDR_ACK : IGNORE;
        ADDR_ACK:  state_d = shreg_q[0] ? RDATA : PTR;
        PTR:       if (bit_cnt_q == 4'd8) state_d = PTR_ACK;
        PTR_ACK:   state_d = WDATA;
        WDATA:     if (bit_cnt_q == 4'd8) state_d = WDATA_ACK;
        WDATA_ACK: state_d = WDATA;
        RDATA:     if (bit_cnt_q == 4'd8) state_d = RMACK;
        RMACK:     state_d = mack_q ? RDATA : IGNORE;
        default:   ;
      endcase
    end
  end

  // ---------------- FSM: output (SDA drive, updated on SCL falls) ----------------
  always_comb begin
    oe_d = oe_q;
    if (start_det || stop_det) oe_d = 1'b0;
    else if (scl_fall) begin
      unique case (state_d)
        ADDR_ACK, PTR_ACK, WDATA_ACK: oe_d = 1'b1;
        RDATA:                        oe_d = ~tx_cur[7];
        default:                      oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) oe_q <= 1'b0;
    else         oe_q <= oe_d;
  end

  // ---------------- bus datapath ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      msb_q     <= '0;
      tx_sr_q   <= '0;
      ptr_q     <= '0;
      wbyte_q   <= '0;
      rd_idx_q  <= '0;
      mack_q    <= 1'b0;
      shadow_q  <= '0;
    end else if (start_det || stop_det) begin
      bit_cnt_q <= '0;
      wbyte_q   <= '0;
      rd_idx_q  <= '0;
    end else if (scl_rise) begin
      unique case (state_q)
        ADDR, PTR, WDATA: if (bit_cnt_q != 4'd8) begin
          shreg_q   <= {shreg_q[6:0], sda_s};
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end
        RDATA:   if (bit_cnt_q != 4'd8) bit_cnt_q <= bit_cnt_q + 4'd1;
        RMACK:   mack_q <= ~sda_s;
        default: ;
      endcase
    end else if (scl_fall) begin
      if (state_d != state_q) bit_cnt_q <= '0;
      if (state_d == RDATA)   tx_sr_q   <= tx_cur;
      unique case (state_q)
        ADDR:    if (state_d == ADDR_ACK) shadow_q <= reg_rd;
        PTR:     if (bit_cnt_q == 4'd8) ptr_q <= shreg_q[1:0];
        WDATA:   if (bit_cnt_q == 4'd8) begin
          if (wbyte_q == 2'd0) msb_q <= shreg_q;
          if (wbyte_q != 2'd2) wbyte_q <= wbyte_q + 2'd1;
        end
        RMACK:   if (mack_q && rd_idx_q != 2'd2) rd_idx_q <= rd_idx_q + 2'd1;
        default: ;
      endcase
    end
  end

  // ---------------- config + conversion timer ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q    <= CONFIG_RST;
      cfg_wr_q <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      conv_q   <= '0;
    end else begin
      cfg_wr_q <= commit;
      if (commit) cfg_q <= {1'b0, commit_data[14:0]};
      if (commit && commit_data[15] && !busy_q) begin
        busy_q <= 1'b1;
        cnt_q  <= CW'(CONV_CYCLES);
      end else if (busy_q) begin
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          conv_q <= conv_data_i;
        end else begin
          cnt_q <= cnt_q - CW'(1);
        end
      end
    end
  end

  assign sda_oe_o    = oe_q;
  assign config_o    = cfg_q;
  assign config_wr_o = cfg_wr_q;
  assign busy_o      = busy_q;
endmodule

// File: tb/tb_ads_i2c_target.sv
// Randomized bench for ads_i2c_target. A bit-banged I2C initiator drives the
// bus, and a register-level model predicts read data, config and conversion.
module tb_ads_i2c_target;
  localparam int         CONV = 1500;
  localparam int         Q    = 10;       // quarter SCL period in clk cycles
  localparam logic [6:0] ADR  = 7'b1001001;

  logic        clk = 1'b0, rst_n = 1'b0, scl = 1'b1, sda_m = 1'b1;
  logic [15:0] conv_data = 16'h0;
  logic        sda_oe, cfg_wr, busy, sda_line;
  logic [15:0] cfg;

  assign sda_line = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  ads_i2c_target #(.CONV_CYCLES(CONV)) dut (
    .clk_i(clk), .rst_ni(rst_n), .scl_i(scl), .sda_i(sda_line),
    .sda_oe_o(sda_oe), .conv_data_i(conv_data), .config_o(cfg),
    .config_wr_o(cfg_wr), .busy_o(busy)
  );

  int n_chk = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ---------- passive monitors ----------
  int   wr_pulses = 0, busy_run = 0, busy_last = 0, oe_viol = 0, busy_misalign = 0;
  logic oe_prev = 1'b0, busy_prev = 1'b0, oe_seen = 1'b0;
  always @(negedge clk) begin
    if (cfg_wr) wr_pulses++;
    if (busy) busy_run++;
    else if (busy_run != 0) begin busy_last = busy_run; busy_run = 0; end
    if (busy && !busy_prev && !cfg_wr) busy_misalign++;
    if (rst_n && sda_oe != oe_prev && scl) oe_viol++;
    if (sda_oe) oe_seen = 1'b1;
    oe_prev   = sda_oe;
    busy_prev = busy;
  end

  // ---------- reference model ----------
  logic [15:0] m_cfg = 16'h8583, m_conv = 16'h0;
  logic [1:0]  m_ptr = 2'd0;
  int          m_wr  = 0;

  function automatic logic [15:0] m_reg(input logic [1:0] p, input bit busy_now);
    case (p)
      2'd0:    return m_conv;
      2'd1:    return {~busy_now, m_cfg[14:0]};
      2'd2:    return 16'h8000;
      default: return 16'h7FFF;
    endcase
  endfunction

  // Expected bytes of an n-byte read, packed oldest-first into the low bits.
  function automatic logic [23:0] m_read(input logic [1:0] p, input int nb, input bit busy_now);
    logic [15:0] r;
    logic [23:0] e;
    r = m_reg(p, busy_now);
    e = '0;
    for (int i = 0; i < nb; i++)
      e = {e[15:0], (i == 0) ? r[15:8] : (i == 1) ? r[7:0] : 8'hFF};
    return e;
  endfunction

  // ---------- bus initiator ----------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q); scl = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q); scl = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q); scl = 1'b1; wait_clk(Q); sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wait_clk(Q); scl = 1'b1; wait_clk(2 * Q); scl = 1'b0; wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_clk(Q); scl = 1'b1; wait_clk(Q);
    b = sda_line; wait_clk(Q); scl = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output int ack);
    logic a;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(a);
    ack = a ? 0 : 1;
  endtask

  task automatic read_byte(input bit ack, output logic [7:0] d);
    logic b;
    d = '0;
    for (int i = 0; i < 8; i++) begin read_bit(b); d = {d[6:0], b}; end
    write_bit(~ack);
  endtask

  // START, address+W, pointer byte, nb data bytes, STOP. Returns ACK count.
  task automatic xfer_write(input logic [1:0] p, input int nb, input logic [15:0] d,
                            output int acks);
    int a;
    acks = 0;
    i2c_start();
    write_byte({ADR, 1'b0}, a); acks += a;
    write_byte({6'($urandom), p}, a); acks += a;
    if (nb >= 1) begin write_byte(d[15:8], a); acks += a; end
    if (nb >= 2) begin write_byte(d[7:0], a); acks += a; end
    if (nb >= 3) begin write_byte(8'($urandom), a); acks += a; end
    i2c_stop();
  endtask

  // Optional pointer write + repeated START, then an nb-byte read that ends in
  // a NACK. The caller issues STOP.
  task automatic xfer_read(input bit with_ptr, input logic [1:0] p, input int nb,
                           output logic [23:0] rd, output int acks);
    int a;
    logic [7:0] b;
    acks = 0;
    rd   = '0;
    if (with_ptr) begin
      i2c_start();
      write_byte({ADR, 1'b0}, a); acks += a;
      write_byte({6'($urandom), p}, a); acks += a;
    end
    i2c_start();
    write_byte({ADR, 1'b1}, a); acks += a;
    for (int i = 0; i < nb; i++) begin
      read_byte(i != nb - 1, b);
      rd = {rd[15:0], b};
    end
  endtask

  task automatic wait_busy_fall();
    int t = 0;
    while (busy && t < CONV + 100) begin wait_clk(1); t++; end
    check("busy_fall_timeout", busy, 1'b0);
    wait_clk(2);
    check("busy_width", busy_last, CONV);
  endtask

`ifdef ADS_TARGET_GLITCH_FILTER_EN
  task automatic write_bit_glitch();
    sda_m = 1'b1; wait_clk(Q); scl = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(1); sda_m = 1'b1;
    wait_clk(Q); scl = 1'b0; wait_clk(Q);
  endtask
`endif

  // ---------- stimulus ----------
  initial begin
    int          acks;
    logic [23:0] rd;
    wait_clk(3);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_config", cfg, 16'h8583);
    check("rst_config_wr", cfg_wr, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    wait_clk(5);

    // Config write with OS=1 starts a conversion.
    conv_data = 16'h1234;
    xfer_write(2'd1, 2, 16'hC383, acks);
    m_ptr = 2'd1; m_cfg = 16'h4383; m_wr++;
    check("cfg_wr_acks", acks, 4);
    check("cfg_value", cfg, 16'h4383);
    check("cfg_wr_pulses", wr_pulses, m_wr);
    check("busy_started", busy, 1'b1);
    // Config read while busy shows bit15 = 0.
    xfer_read(1'b0, 2'd1, 2, rd, acks);
    i2c_stop();
    check("rd_cfg_busy", rd[15:0], m_read(2'd1, 2, 1'b1));
    wait_busy_fall();
    m_conv = conv_data;
    xfer_read(1'b0, 2'd1, 2, rd, acks);
    i2c_stop();
    check("rd_cfg_idle", rd[15:0], m_read(2'd1, 2, 1'b0));

    // Pointer 0, repeated START, read conversion result.
    xfer_read(1'b1, 2'd0, 2, rd, acks);
    m_ptr = 2'd0;
    check("rd_conv_acks", acks, 3);
    check("rd_conv", rd[15:0], 16'h1234);
    check("released_after_nack", sda_oe, 1'b0);
    i2c_stop();

    // A wrong address is never acknowledged, and the target never drives SDA.
    oe_seen = 1'b0;
    i2c_start();
    write_byte({7'b1001000, 1'b0}, acks);
    check("bad_addr_ack", acks, 0);
    write_byte(8'h01, acks);
    i2c_stop();
    check("bad_addr_oe", oe_seen, 1'b0);
    check("bad_addr_cfg", cfg, m_cfg);

    // Reset mid-read while the target drives a 0 bit (MSB of 8'h12).
    i2c_start();
    write_byte({ADR, 1'b1}, acks);
    sda_m = 1'b1; wait_clk(Q); scl = 1'b1; wait_clk(Q);
    check("pre_reset_drive", sda_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    check("reset_release_async", sda_oe, 1'b0);
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(5);
    m_cfg = 16'h8583; m_conv = 16'h0; m_ptr = 2'd0;
    check("post_reset_cfg", cfg, 16'h8583);
    xfer_write(2'd1, 2, 16'h0123, acks);
    m_ptr = 2'd1; m_cfg = 16'h0123; m_wr++;
    check("post_reset_acks", acks, 4);
    check("post_reset_cfg_wr", cfg, 16'h0123);
    xfer_read(1'b1, 2'd0, 2, rd, acks);
    i2c_stop();
    m_ptr = 2'd0;
    check("post_reset_conv", rd[15:0], m_read(2'd0, 2, 1'b0));

    // Randomized transactions against the model.
    for (int it = 0; it < 16; it++) begin
      int          op, nb;
      logic [1:0]  p;
      logic [15:0] d;
      bit          conv;
      op = $urandom_range(0, 1);
      if (op == 0) begin
        p    = 2'($urandom);
        nb   = $urandom_range(0, 3);
        d    = 16'($urandom);
        conv = (p == 2'd1) && (nb >= 2) && d[15];
        if (conv) conv_data = 16'($urandom);
        xfer_write(p, nb, d, acks);
        check("rnd_wr_acks", acks, nb + 2);
        m_ptr = p;
        if (p == 2'd1 && nb >= 2) begin m_cfg = {1'b0, d[14:0]}; m_wr++; end
        check("rnd_cfg", cfg, m_cfg);
        check("rnd_busy", busy, conv);
        if (conv) begin
          wait_busy_fall();
          m_conv = conv_data;
        end
      end else begin
        bit wp;
        wp = 1'($urandom);
        p  = wp ? 2'($urandom) : m_ptr;
        nb = $urandom_range(1, 3);
        xfer_read(wp, p, nb, rd, acks);
        m_ptr = p;
        check("rnd_rd_acks", acks, wp ? 3 : 1);
        check("rnd_rd_data", rd, m_read(p, nb, 1'b0));
        check("rnd_rd_release", sda_oe, 1'b0);
        i2c_stop();
      end
    end

`ifdef ADS_TARGET_GLITCH_FILTER_EN
    // A 1-cycle SDA low pulse with SCL high, inside the pointer byte's last bit,
    // must not be seen as START/STOP.
    begin
      int a;
      acks = 0;
      i2c_start();
      write_byte({ADR, 1'b0}, a); acks += a;
      for (int i = 7; i >= 1; i--) write_bit(1'b0);
      write_bit_glitch();
      read_bit(sda_m); acks += (sda_m ? 0 : 1);
      write_byte(8'h12, a); acks += a;
      write_byte(8'h34, a); acks += a;
      i2c_stop();
      m_ptr = 2'd1; m_cfg = 16'h1234; m_wr++;
      check("glitch_acks", acks, 4);
      check("glitch_cfg", cfg, m_cfg);
    end
`endif

    wait_clk(5);
    check("total_cfg_wr_pulses", wr_pulses, m_wr);
    check("oe_change_scl_high", oe_viol, 0);
    check("busy_rise_alignment", busy_misalign, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
